sum_accumulator: RTL and testbench



---
 rtl/sum_accumulator.sv | 115 +++++++++++
 tb/tb_sum_accumulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// First sequential stage after the combinational 4-bit adder. Each accepted
// sample is the adder result {cout,sum}. NUM_SAMPLES samples are summed
// (modulo 2^ACC_W) into acc_out. Once the set is complete, the total is
// presented with acc_valid and held until out_ack. The overflow flag is
// sticky for the duration of a run.
//
// Ports:
//   clk         in   system clock, rising-edge
//   rst         in   synchronous active-high reset
//   start       in   begin a new run (honoured only when idle)
//   sum         in   [DATA_W-1:0] adder sum
//   cout        in   adder carry-out
//   in_valid    in   sum/cout valid this cycle
//   in_ready    out  a sample is accepted this cycle if in_valid is high
//   acc_out     out  [ACC_W-1:0] running / final total
//   acc_valid   out  acc_out is final and stable
//   out_ack     in   consumer has taken acc_out
//   overflow    out  accumulator wrapped during the current run (sticky)
//   sample_cnt  out  [CNT_W-1:0] samples accepted in the current run
// ---------------------------------------------------------------------------
module sum_accumulator #(
  parameter int DATA_W      = 4,
  parameter int ACC_W       = 8,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] sum,
  input  logic              cout,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              out_ack,
  output logic              overflow,
  output logic [CNT_W-1:0]  sample_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Count value held by the counter while the final sample of a run is
  // being accepted.
  localparam logic [CNT_W-1:0] LP_LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  // Zero-extends the adder result and adds it to the current total; the
  // top bit of the result is the wrap indication.
  function automatic logic [ACC_W:0] f_acc_add(
    input logic [ACC_W-1:0] acc,
    input logic [DATA_W:0]  smp
  );
    f_acc_add = {1'b0, acc} + (ACC_W + 1)'(smp);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last;
  logic               w_start_run;
  logic [ACC_W:0]     w_sum_ext;

  assign in_ready    = (r_state == ACCUM);
  assign acc_valid   = (r_state == DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_cnt == LP_LAST_IDX);
  assign w_start_run = (r_state == IDLE) && start;
  assign w_sum_ext   = f_acc_add(r_acc, {cout, sum});

  assign acc_out    = r_acc;
  assign overflow   = r_ovf;
  assign sample_cnt = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)              w_state_nxt = ACCUM;
      ACCUM:   if (w_accept && w_last) w_state_nxt = DONE;
      DONE:    if (out_ack)            w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_run) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_acc <= w_sum_ext[ACC_W-1:0];
        if (w_sum_ext[ACC_W]) r_ovf <= 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

  localparam int ACC_W  = 8;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  // Three instances: NUM_SAMPLES = 4, 9, 1.
  int ns[3] = '{4, 9, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a [3];
  logic              st    [3];
  logic              iv    [3];
  logic              ack   [3];
  logic              co    [3];
  logic [DATA_W-1:0] sm    [3];
  logic              ir    [3];
  logic              av    [3];
  logic              ov    [3];
  logic [ACC_W-1:0]  acc   [3];
  logic [CNT_W-1:0]  cnt   [3];

  sum_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_SAMPLES(4), .CNT_W(CNT_W)) u_n4 (
    .clk(clk), .rst(rst_a[0]), .start(st[0]), .sum(sm[0]), .cout(co[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .acc_out(acc[0]), .acc_valid(av[0]),
    .out_ack(ack[0]), .overflow(ov[0]), .sample_cnt(cnt[0]));

  sum_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_SAMPLES(9), .CNT_W(CNT_W)) u_n9 (
    .clk(clk), .rst(rst_a[1]), .start(st[1]), .sum(sm[1]), .cout(co[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .acc_out(acc[1]), .acc_valid(av[1]),
    .out_ack(ack[1]), .overflow(ov[1]), .sample_cnt(cnt[1]));

  sum_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_SAMPLES(1), .CNT_W(CNT_W)) u_n1 (
    .clk(clk), .rst(rst_a[2]), .start(st[2]), .sum(sm[2]), .cout(co[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .acc_out(acc[2]), .acc_valid(av[2]),
    .out_ack(ack[2]), .overflow(ov[2]), .sample_cnt(cnt[2]));

  int checks   = 0;
  int failures = 0;
  longint cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     k;
    int     acc;
    int     ovf;
    int     cnt;
    longint cyc;
  } exp_t;
  exp_t sbq[$];

  // Reference model: phase 0 = waiting for start, 1 = collecting, 2 = holding result.
  // The total is kept unbounded; the visible accumulator is total mod 256 and,
  // since samples are non-negative, the sticky wrap flag is simply total >= 256.
  int m_ph  [3];
  int m_tot [3];
  int m_cnt [3];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_state(input int k);
    chk($sformatf("i%0d_in_ready", k),   ir[k],  (m_ph[k] == 1));
    chk($sformatf("i%0d_acc_valid", k),  av[k],  (m_ph[k] == 2));
    chk($sformatf("i%0d_acc_out", k),    acc[k], m_tot[k] % 256);
    chk($sformatf("i%0d_overflow", k),   ov[k],  (m_tot[k] >= 256));
    chk($sformatf("i%0d_sample_cnt", k), cnt[k], m_cnt[k]);
  endtask

  // One clock cycle on instance k: drive inputs, clock, advance the model,
  // then compare every visible output.
  task automatic step(input int k, input bit s_st, input bit s_v, input int s_val,
                      input bit s_ack, input bit s_rst);
    logic [4:0] v;
    bit push;
    v      = 5'(s_val);
    push   = 1'b0;
    st[k]  = s_st;
    iv[k]  = s_v;
    co[k]  = v[4];
    sm[k]  = v[3:0];
    ack[k] = s_ack;
    rst_a[k] = s_rst;
    @(posedge clk);
    if (s_rst) begin
      m_ph[k] = 0; m_tot[k] = 0; m_cnt[k] = 0;
    end else if (m_ph[k] == 0) begin
      if (s_st) begin m_ph[k] = 1; m_tot[k] = 0; m_cnt[k] = 0; end
    end else if (m_ph[k] == 1) begin
      if (s_v) begin
        m_tot[k] += int'(v);
        m_cnt[k]++;
        if (m_cnt[k] == ns[k]) begin m_ph[k] = 2; push = 1'b1; end
      end
    end else begin
      if (s_ack) m_ph[k] = 0;
    end
    #1;
    if (push) sbq.push_back('{k, m_tot[k] % 256, int'(m_tot[k] >= 256), m_cnt[k], cyc});
    st[k] = 1'b0; iv[k] = 1'b0; ack[k] = 1'b0; rst_a[k] = 1'b0;
    chk_state(k);
  endtask

  // Randomized run: random idle gap, start, gapped random samples with
  // stray start pulses, random hold in DONE with stray samples, then ack.
  task automatic rand_run(input int k);
    int guard;
    int hold;
    repeat ($urandom_range(0, 2)) step(k, 0, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1), 0);
    step(k, 1, 0, 0, 0, 0);
    guard = 0;
    while (m_ph[k] == 1 && guard < 200) begin
      step(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 31), 0, 0);
      guard++;
    end
    chk($sformatf("i%0d_rand_reached_done", k), m_ph[k], 2);
    hold = $urandom_range(0, 3);
    repeat (hold) step(k, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), 0, 0);
    step(k, $urandom_range(0, 1), 0, 0, 1, 0);
  endtask

  // Scoreboard monitor: a rising acc_valid is the DUT presenting a result.
  bit av_prev[3];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (av[k] === 1'b1 && !av_prev[k]) begin
        if (sbq.size() == 0) begin
          chk($sformatf("i%0d_sb_unexpected_result", k), 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("i%0d_sb_instance", k), k, e.k);
          chk($sformatf("i%0d_sb_acc", k), acc[k], e.acc);
          chk($sformatf("i%0d_sb_ovf", k), ov[k], e.ovf);
          chk($sformatf("i%0d_sb_cnt", k), cnt[k], e.cnt);
          chk($sformatf("i%0d_sb_latency_cycle", k), cyc, e.cyc);
        end
      end
      av_prev[k] <= (av[k] === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = 1'b1; st[k] = 1'b1; iv[k] = 1'b1; ack[k] = 1'b0; co[k] = 1'b0; sm[k] = '0;
      m_ph[k] = 0; m_tot[k] = 0; m_cnt[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = 1'b0; st[k] = 1'b0; iv[k] = 1'b0;
      chk_state(k);
    end

    // Back-to-back 1,3,5,7 -> 0x10, then ack.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 5, 0, 0);
    step(0, 0, 1, 7, 0, 0);
    chk("tp1_acc", acc[0], 16);
    chk("tp1_valid", av[0], 1);
    chk("tp1_cnt", cnt[0], 4);
    step(0, 0, 0, 0, 1, 0);
    chk("tp1_after_ack_valid", av[0], 0);

    // Gapped input: valid 1,0,0,1,0,1,1 with sample 2.
    step(0, 1, 0, 0, 0, 0);
    foreach (ns[i]) begin end
    begin
      bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      for (int i = 0; i < 7; i++) step(0, 0, pat[i], 2, 0, 0);
    end
    chk("tp2_acc", acc[0], 8);
    chk("tp2_done", av[0], 1);
    step(0, 0, 0, 0, 1, 0);

    // Overflow on NUM_SAMPLES = 9: nine samples of 31.
    step(1, 1, 0, 0, 0, 0);
    repeat (9) step(1, 0, 1, 31, 0, 0);
    chk("tp3_acc", acc[1], 23);
    chk("tp3_ovf", ov[1], 1);
    step(1, 0, 0, 0, 1, 0);
    chk("tp3_ovf_held_idle", ov[1], 1);
    step(1, 1, 0, 0, 0, 0);
    chk("tp3_ovf_cleared", ov[1], 0);
    chk("tp3_acc_cleared", acc[1], 0);
    repeat (9) step(1, 0, 1, $urandom_range(0, 31), 0, 0);
    step(1, 0, 0, 0, 1, 0);

    // Hold in DONE for 10 cycles with stray samples, then start+ack together.
    step(0, 1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, $urandom_range(0, 31), 0, 0);
    repeat (10) step(0, 0, 1, 5, 0, 0);
    chk("tp4_still_valid", av[0], 1);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("tp4_no_new_run_ready", ir[0], 0);

    // Reset mid-run after two samples of 2.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0);
    step(0, 0, 1, 2, 0, 0);
    chk("tp5_partial_acc", acc[0], 4);
    step(0, 0, 1, 2, 0, 1);
    chk("tp5_rst_acc", acc[0], 0);
    chk("tp5_rst_cnt", cnt[0], 0);
    // Start pulses during a run do not clear it.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    chk("tp5_start_ignored_acc", acc[0], 6);
    step(0, 1, 0, 0, 0, 0);
    chk("tp5_start_ignored_cnt", cnt[0], 2);
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    // NUM_SAMPLES = 1: single sample of 16.
    step(2, 1, 0, 0, 0, 0);
    step(2, 0, 1, 16, 0, 0);
    chk("tp6_acc", acc[2], 16);
    chk("tp6_valid", av[2], 1);
    step(2, 0, 0, 0, 1, 0);

    // Randomized runs on every instance.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 3; k++) rand_run(k);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_leftover", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
